// File: rtl/alu_pkg.sv
// ALU operation encoding shared by decode, execute and the ALU itself.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10
  } alu_op_t;

endpackage

// File: rtl/exu_pkg.sv
// Execute-stage types: control-flow class and instruction size.
package exu_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_type_t;

  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unknown operations produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] res
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = $signed(a) >>> shamt;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  res = a ^ b;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      ALU_EQ:   res = {{(XLEN-1){1'b0}}, a == b};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/exu.sv
// Execute stage: operand select, ALU, branch/jump resolution and the single
// decode-to-writeback pipeline register with valid/ready handshakes.
module exu
  import alu_pkg::*;
  import exu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  alu_op_t         in_alu_op,
  input  logic            in_src1_pc,
  input  logic            in_src2_imm,
  input  br_type_t        in_br,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_redirect_pc
);

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] link_pc;
  logic            accept;
  logic            drain;
  logic            rd_we_eff;

  logic [XLEN-1:0] nxt_result;
  logic            nxt_rd_we;
  logic            nxt_redirect;
  logic [XLEN-1:0] nxt_redirect_pc;

  assign alu_a = in_src1_pc  ? in_pc  : in_rs1;
  assign alu_b = in_src2_imm ? in_imm : in_rs2;

  alu #(
    .XLEN (XLEN)
  ) alu_inst (
    .a   (alu_a),
    .b   (alu_b),
    .op  (in_alu_op),
    .res (alu_res)
  );

  assign br_target = in_pc + in_imm;
  assign link_pc   = in_pc + XLEN'(INSN_BYTES);
  assign rd_we_eff = in_rd_we && (in_rd != 5'd0);

  // Ready depends only on the output side, never on in_valid.
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_comb begin
    nxt_result      = alu_res;
    nxt_rd_we       = rd_we_eff;
    nxt_redirect    = 1'b0;
    nxt_redirect_pc = '0;
    case (in_br)
      BR_BEQ, BR_BLT, BR_BLTU: begin
        nxt_result      = '0;
        nxt_rd_we       = 1'b0;
        nxt_redirect    = alu_res[0];
        nxt_redirect_pc = br_target;
      end
      BR_BNE, BR_BGE, BR_BGEU: begin
        nxt_result      = '0;
        nxt_rd_we       = 1'b0;
        nxt_redirect    = ~alu_res[0];
        nxt_redirect_pc = br_target;
      end
      BR_JAL: begin
        nxt_result      = link_pc;
        nxt_redirect    = 1'b1;
        nxt_redirect_pc = alu_res;
      end
      BR_JALR: begin
        nxt_result      = link_pc;
        nxt_redirect    = 1'b1;
        nxt_redirect_pc = {alu_res[XLEN-1:1], 1'b0};
      end
      default: begin
        nxt_result      = alu_res;
        nxt_redirect    = 1'b0;
        nxt_redirect_pc = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_result      <= '0;
      out_rd          <= '0;
      out_rd_we       <= 1'b0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_pc          <= in_pc;
      out_result      <= nxt_result;
      out_rd          <= in_rd;
      out_rd_we       <= nxt_rd_we;
      out_redirect    <= nxt_redirect;
      out_redirect_pc <= nxt_redirect_pc;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exu.sv
// Directed bench for exu: vector table plus hand-written reset, stall,
// drain and flush sequences.
module tb_exu;
  import alu_pkg::*;
  import exu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  alu_op_t         in_alu_op;
  logic            in_src1_pc;
  logic            in_src2_imm;
  br_type_t        in_br;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_redirect;
  logic [XLEN-1:0] out_redirect_pc;

  exu #(
    .XLEN (XLEN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_imm          (in_imm),
    .in_alu_op       (in_alu_op),
    .in_src1_pc      (in_src1_pc),
    .in_src2_imm     (in_src2_imm),
    .in_br           (in_br),
    .in_rd           (in_rd),
    .in_rd_we        (in_rd_we),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_result      (out_result),
    .out_rd          (out_rd),
    .out_rd_we       (out_rd_we),
    .out_redirect    (out_redirect),
    .out_redirect_pc (out_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    alu_op_t     op;
    logic        s1pc;
    logic        s2imm;
    br_type_t    br;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] e_res;
    logic        e_we;
    logic        e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  int unsigned n_vec;
  int unsigned n_err;
  vec_t        vecs[$];

  function automatic vec_t mk(string nm, alu_op_t op, logic s1pc, logic s2imm,
                              br_type_t br, logic [31:0] pc, logic [31:0] rs1,
                              logic [31:0] rs2, logic [31:0] imm, logic [4:0] rd,
                              logic we, logic [31:0] e_res, logic e_we,
                              logic e_redir, logic [31:0] e_rpc);
    vec_t v;
    v.nm = nm; v.op = op; v.s1pc = s1pc; v.s2imm = s2imm; v.br = br;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.rd = rd; v.we = we;
    v.e_res = e_res; v.e_we = e_we; v.e_redir = e_redir; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid    = 1'b1;
    in_alu_op   = v.op;
    in_src1_pc  = v.s1pc;
    in_src2_imm = v.s2imm;
    in_br       = v.br;
    in_pc       = v.pc;
    in_rs1      = v.rs1;
    in_rs2      = v.rs2;
    in_imm      = v.imm;
    in_rd       = v.rd;
    in_rd_we    = v.we;
  endtask

  task automatic check_out(input vec_t v);
    chk({v.nm, ".valid"},  32'(out_valid),    32'd1);
    chk({v.nm, ".pc"},     out_pc,            v.pc);
    chk({v.nm, ".result"}, out_result,        v.e_res);
    chk({v.nm, ".rd"},     32'(out_rd),       32'(v.rd));
    chk({v.nm, ".rd_we"},  32'(out_rd_we),    32'(v.e_we));
    chk({v.nm, ".redir"},  32'(out_redirect), 32'(v.e_redir));
    if (v.e_redir)
      chk({v.nm, ".target"}, out_redirect_pc, v.e_rpc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sa, sb, fc;
    n_vec = 0;
    n_err = 0;

    //      name     op        s1pc  s2imm br       pc            rs1           rs2          imm           rd    we    res           we    rdr   target
    vecs.push_back(mk("add",   ALU_ADD,  1'b0, 1'b0, BR_NONE, 32'h0000_0000, 32'd5,        32'd7,       32'd0,        5'd3, 1'b1, 32'd12,       1'b1, 1'b0, 32'h0));
    vecs.push_back(mk("sub",   ALU_SUB,  1'b0, 1'b0, BR_NONE, 32'h0000_0004, 32'd1,        32'd2,       32'd0,        5'd4, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk("sra",   ALU_SRA,  1'b0, 1'b1, BR_NONE, 32'h0000_0008, 32'h8000_0000, 32'd0,      32'd4,        5'd5, 1'b1, 32'hF800_0000, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk("sll",   ALU_SLL,  1'b0, 1'b0, BR_NONE, 32'h0000_000C, 32'd1,        32'h21,      32'd0,        5'd6, 1'b1, 32'd2,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mk("undef", alu_op_t'(4'hF), 1'b0, 1'b0, BR_NONE, 32'h10, 32'd9,       32'd9,       32'd0,        5'd7, 1'b1, 32'd0,        1'b1, 1'b0, 32'h0));
    vecs.push_back(mk("blt",   ALU_SLT,  1'b0, 1'b0, BR_BLT,  32'h0000_0100, 32'hFFFF_FFFF, 32'd1,      32'h20,       5'd8, 1'b1, 32'd0,        1'b0, 1'b1, 32'h120));
    vecs.push_back(mk("bltu",  ALU_SLTU, 1'b0, 1'b0, BR_BLTU, 32'h0000_0100, 32'hFFFF_FFFF, 32'd1,      32'h20,       5'd8, 1'b1, 32'd0,        1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("bne",   ALU_EQ,   1'b0, 1'b0, BR_BNE,  32'h0000_0100, 32'd4,        32'd4,       32'h20,       5'd8, 1'b1, 32'd0,        1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("beq",   ALU_EQ,   1'b0, 1'b0, BR_BEQ,  32'h0000_0100, 32'd3,        32'd3,       32'h20,       5'd8, 1'b1, 32'd0,        1'b0, 1'b1, 32'h120));
    vecs.push_back(mk("bge",   ALU_SLT,  1'b0, 1'b0, BR_BGE,  32'h0000_0100, 32'hFFFF_FFFF, 32'd1,      32'h20,       5'd8, 1'b1, 32'd0,        1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("jalr",  ALU_ADD,  1'b0, 1'b1, BR_JALR, 32'h0000_0200, 32'h1003,     32'd0,       32'd4,        5'd1, 1'b1, 32'h204,      1'b1, 1'b1, 32'h1006));
    vecs.push_back(mk("jal",   ALU_ADD,  1'b1, 1'b1, BR_JAL,  32'h0000_0200, 32'd0,        32'd0,       32'hFFFF_FFF8, 5'd0, 1'b1, 32'h204,      1'b0, 1'b1, 32'h1F8));

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(vecs[0]);

    // Reset with a valid instruction offered: it must be discarded.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.in_ready",  32'(in_ready),     32'd0);
    chk("rst.valid",     32'(out_valid),    32'd0);
    chk("rst.result",    out_result,        32'd0);
    chk("rst.pc",        out_pc,            32'd0);
    chk("rst.rd",        32'(out_rd),       32'd0);
    chk("rst.rd_we",     32'(out_rd_we),    32'd0);
    chk("rst.redir",     32'(out_redirect), 32'd0);
    chk("rst.target",    out_redirect_pc,   32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream with out_ready held high: one result per edge.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check_out(vecs[i]);
      @(negedge clk);
    end

    // Stall: A is held for three edges while B waits on the input.
    sa = mk("stallA", ALU_ADD, 1'b0, 1'b0, BR_NONE, 32'h300, 32'd10, 32'd20, 32'd0, 5'd4, 1'b1, 32'd30, 1'b1, 1'b0, 32'h0);
    sb = mk("stallB", ALU_SUB, 1'b0, 1'b0, BR_NONE, 32'h304, 32'd50, 32'd8,  32'd0, 5'd6, 1'b1, 32'd42, 1'b1, 1'b0, 32'h0);
    drive(sa);
    @(posedge clk); #1;
    check_out(sa);
    @(negedge clk);
    out_ready = 1'b0;
    drive(sb);
    for (int unsigned c = 0; c < 3; c++) begin
      #1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check_out(sa);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("stall.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check_out(sb);

    // Drain without a new instruction leaves a bubble.
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Flush concurrent with an accept drops the instruction.
    @(negedge clk);
    fc = mk("flushC", ALU_ADD, 1'b0, 1'b0, BR_NONE, 32'h400, 32'd1, 32'd1, 32'd0, 5'd7, 1'b1, 32'd2, 1'b1, 1'b0, 32'h0);
    drive(fc);
    flush = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("flush.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush.after_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
